// File: rtl/csr_bank_if.sv
// csr_bank_if: CSR read/write port, trap/return events, counter and interrupt signals of csr_bank
interface csr_bank_if #(
    parameter int XLEN = 32
);
    logic [11:0]     raddr;
    logic [XLEN-1:0] rdata;
    logic            rvalid;
    logic            we;
    logic [11:0]     waddr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      wop;
    logic            csr_illegal;
    logic            trap;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_val;
    logic [XLEN-1:0] trap_pc;
    logic            mret;
    logic            instret_inc;
    logic            irq_ext;
    logic            irq_timer;
    logic            irq_sw;
    logic            irq_pending;
    logic [XLEN-1:0] irq_cause;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mstatus;

    modport master (
        output raddr, we, waddr, wdata, wop, trap, trap_cause, trap_val, trap_pc,
               mret, instret_inc, irq_ext, irq_timer, irq_sw,
        input  rdata, rvalid, csr_illegal, irq_pending, irq_cause, trap_target, mepc, mstatus
    );

    modport slave (
        input  raddr, we, waddr, wdata, wop, trap, trap_cause, trap_val, trap_pc,
               mret, instret_inc, irq_ext, irq_timer, irq_sw,
        output rdata, rvalid, csr_illegal, irq_pending, irq_cause, trap_target, mepc, mstatus
    );
endinterface

// File: rtl/csr_bank.sv
// csr_bank: machine-mode CSR file with trap/mret sequencing, interrupt arbitration and 64-bit counters
module csr_bank #(
    parameter int              XLEN        = 32,
    parameter logic            VEC_EN      = 1'b1,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic            CNT_EN      = 1'b1
) (
    input logic       clk,
    input logic       rst,
    csr_bank_if.slave bus
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    localparam logic [XLEN-1:0] MIE_MASK  = XLEN'(32'h0000_0888);
    localparam logic [XLEN-1:0] ALIGN     = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] CAUSE_EXT = {1'b1, (XLEN-1)'(11)};
    localparam logic [XLEN-1:0] CAUSE_SW  = {1'b1, (XLEN-1)'(3)};
    localparam logic [XLEN-1:0] CAUSE_TMR = {1'b1, (XLEN-1)'(7)};

    logic            st_mie_q, st_mie_d;
    logic            st_mpie_q, st_mpie_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic [XLEN-1:0] mstatus_v;
    logic [XLEN-1:0] mip_v;
    logic [XLEN-1:0] irq_act;
    logic            irq_pend;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] wr_old;
    logic [XLEN-1:0] wres;
    logic            wr_en;
    logic            mode_ok;

    // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
    assign mstatus_v = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, st_mpie_q, 3'b000, st_mie_q, 3'b000};
    assign mip_v     = {{(XLEN-12){1'b0}}, bus.irq_ext, 3'b000, bus.irq_timer, 3'b000, bus.irq_sw, 3'b000};
    assign irq_act   = mie_q & mip_v;
    assign irq_pend  = st_mie_q & |irq_act;
    assign tvec_base = mtvec_q & ALIGN;

    function automatic logic csr_impl(input logic [11:0] a);
        return a inside {A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL, A_MIP,
                         A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH,
                         A_CYCLE, A_CYCLEH, A_INSTRET, A_INSTRETH};
    endfunction

    function automatic logic csr_wr_ok(input logic [11:0] a);
        return a inside {A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
                         A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH};
    endfunction

    function automatic logic [XLEN-1:0] csr_val(input logic [11:0] a);
        case (a)
            A_MSTATUS:              return mstatus_v;
            A_MIE:                  return mie_q;
            A_MTVEC:                return mtvec_q;
            A_MSCRATCH:             return mscratch_q;
            A_MEPC:                 return mepc_q;
            A_MCAUSE:               return mcause_q;
            A_MTVAL:                return mtval_q;
            A_MIP:                  return mip_v;
            A_MCYCLE, A_CYCLE:      return mcycle_q[31:0];
            A_MCYCLEH, A_CYCLEH:    return mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:  return minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH: return minstret_q[63:32];
            default:                return '0;
        endcase
    endfunction

    // Read both ports from pre-write state and form the read-modify-write result.
    always_comb begin
        rd_val  = csr_val(bus.raddr);
        wr_old  = csr_val(bus.waddr);
        wres    = bus.wop == 2'b01 ? bus.wdata :
                  bus.wop == 2'b10 ? (wr_old | bus.wdata) :
                  bus.wop == 2'b11 ? (wr_old & ~bus.wdata) : wr_old;
        wr_en   = bus.we && bus.wop != 2'b00 && !bus.trap && !bus.mret && csr_wr_ok(bus.waddr);
        mode_ok = wres[1:0] == 2'b00 || (wres[1:0] == 2'b01 && VEC_EN);
    end

    // Next-state: trap beats mret beats a CSR write; counters tick underneath unless a half is written.
    always_comb begin
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + 64'(bus.instret_inc);
        if (bus.trap) begin
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
            mepc_d    = bus.trap_pc & ALIGN;
            mcause_d  = bus.trap_cause;
            mtval_d   = bus.trap_val;
        end else if (bus.mret) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end else if (wr_en) begin
            case (bus.waddr)
                A_MSTATUS: begin
                    st_mie_d  = wres[3];
                    st_mpie_d = wres[7];
                end
                A_MIE:       mie_d              = wres & MIE_MASK;
                A_MTVEC:     mtvec_d            = {wres[XLEN-1:2], mode_ok ? wres[1:0] : mtvec_q[1:0]};
                A_MSCRATCH:  mscratch_d         = wres;
                A_MEPC:      mepc_d             = wres & ALIGN;
                A_MCAUSE:    mcause_d           = wres;
                A_MTVAL:     mtval_d            = wres;
                A_MCYCLE:    mcycle_d[31:0]     = wres;
                A_MCYCLEH:   mcycle_d[63:32]    = wres;
                A_MINSTRET:  minstret_d[31:0]   = wres;
                A_MINSTRETH: minstret_d[63:32]  = wres;
                default: ;
            endcase
        end
        if (!CNT_EN) begin
            mcycle_d   = '0;
            minstret_d = '0;
        end
    end

    // State registers; reset dominates any event presented during it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign bus.rdata       = rd_val;
    assign bus.rvalid      = csr_impl(bus.raddr);
    assign bus.csr_illegal = bus.we & ~csr_wr_ok(bus.waddr);
    assign bus.mstatus     = mstatus_v;
    assign bus.mepc        = (wr_en && bus.waddr == A_MEPC) ? mepc_d : mepc_q;
    assign bus.irq_pending = irq_pend;
    assign bus.irq_cause   = !irq_pend ? '0 : irq_act[11] ? CAUSE_EXT : irq_act[3] ? CAUSE_SW : CAUSE_TMR;
    assign bus.trap_target = (mtvec_q[1:0] == 2'b01 && bus.trap_cause[XLEN-1]) ?
                             tvec_base + {bus.trap_cause[XLEN-3:0], 2'b00} : tvec_base;
endmodule

// File: doc/csr_bank.md
CSR_BANK -- requirements
Module: csr_bank

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values: 32 only.
REQ-002 SHALL provide parameter VEC_EN, default 1, enables vectored mtvec mode.
REQ-003 SHALL provide parameter RESET_MTVEC, default 32'h0000_0000, mtvec reset value.
REQ-004 SHALL provide parameter CNT_EN, default 1; when 0, mcycle/minstret read 0 and ignore writes.
REQ-005 SHALL use clk and rst as follows: clk, input, 1, clock; rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL provide raddr, input, 12, CSR read address; rdata, output, XLEN, read data; rvalid, output, 1, raddr implemented.
REQ-007 SHALL provide we, input, 1, write strobe; waddr, input, 12; wdata, input, XLEN; wop, input, 2, operation (01 write, 10 set, 11 clear, 00 none).
REQ-008 SHALL provide csr_illegal, output, 1, we to an unimplemented or read-only address.
REQ-009 SHALL provide trap, input, 1; trap_cause, input, XLEN; trap_val, input, XLEN; trap_pc, input, XLEN.
REQ-010 SHALL provide mret, input, 1; instret_inc, input, 1, one instruction retired.
REQ-011 SHALL provide irq_ext, irq_timer, irq_sw, each input, 1, level interrupt lines.
REQ-012 SHALL provide irq_pending, output, 1; irq_cause, output, XLEN; trap_target, output, XLEN; mepc, output, XLEN; mstatus, output, XLEN.

Function
REQ-013 SHALL implement 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip, 0xB00/0xB80 mcycle lo/hi, 0xB02/0xB82 minstret lo/hi, 0xC00/0xC80/0xC02/0xC82 read-only shadows.
REQ-014 SHALL drive rdata combinationally from current register state (pre-write value); unimplemented raddr gives rdata=0, rvalid=0.
REQ-015 SHALL apply writes on the clk edge: wop 01 -> wdata, 10 -> old|wdata, 11 -> old&~wdata, 00 -> no change.
REQ-016 SHALL ignore writes to unimplemented or read-only addresses (0xCxx, mip) and assert csr_illegal combinationally for that cycle.
REQ-017 SHALL keep only mstatus MIE(bit 3) and MPIE(bit 7) writable; MPP(12:11) reads 2'b11; all other bits read 0.
REQ-018 SHALL force mepc[1:0]=0 on every update.
REQ-019 SHALL retain the old mtvec mode field when a written mode is 2 or 3, or is 1 with VEC_EN=0.
REQ-020 SHALL form mip combinationally: bit 11 = irq_ext, bit 7 = irq_timer, bit 3 = irq_sw; only mie bits 11, 7, 3 are writable.
REQ-021 SHALL assert irq_pending = mstatus.MIE & |(mie & mip); priority ext > sw > timer; irq_cause = {1'b1, code 11/3/7}, 0 when none pending.
REQ-022 SHALL compute trap_target: mode 1 and trap_cause[XLEN-1]=1 -> {base,2'b00} + 4*trap_cause[XLEN-2:0]; otherwise {base,2'b00}.
REQ-023 SHALL on trap: MPIE <= MIE, MIE <= 0, mepc <= trap_pc, mcause <= trap_cause, mtval <= trap_val.
REQ-024 SHALL on mret: MIE <= MPIE, MPIE <= 1.
REQ-025 SHALL apply priority trap > mret > we in the same cycle; the lower-priority event is dropped entirely.
REQ-026 SHALL increment 64-bit mcycle every cycle and 64-bit minstret when instret_inc=1, with carry from lo to hi and wrap 2^64-1 -> 0.
REQ-027 SHALL let a counter-half write take effect instead of that cycle's increment on the same half; the other half is unaffected by the write and still receives the increment's carry.
REQ-028 SHALL forward a same-cycle mepc write to the mepc output when we=1, waddr=0x341, and neither trap nor mret is asserted.

Reset
REQ-029 SHALL on rst set mstatus=32'h0000_1800, mtvec=RESET_MTVEC, and all other CSRs and counters to 0; outputs follow combinationally; an event in flight during rst is discarded.

Verification
REQ-030 Trap: mstatus=0x1888, trap=1, trap_cause=0x8000_000B, mtvec=0x0000_1001 -> trap_target=0x102C; next cycle mstatus=0x1880, mcause=0x8000_000B.
REQ-031 Interrupt priority: mie=0x888, MIE=1, irq_timer=irq_sw=1 -> irq_pending=1, irq_cause=0x8000_0003; clearing MIE -> irq_pending=0.
REQ-032 Counter wrap: write mcycle lo 0xFFFF_FFFF, hi 0 -> one cycle later mcycleh=1, mcycle=0.
REQ-033 Simultaneous events: trap+mret+we(mscratch,0x55) -> trap applied, mscratch unchanged; write set/clear: 0xF0 |0x0F -> 0xFF, &~0x3C -> 0xC3.
REQ-034 Illegal: we=1, waddr=0xC00 -> csr_illegal=1, cycle counter unaffected; mtvec write 0x102 -> mode stays 0, reads 0x100.
REQ-035 Reset mid-operation: assert rst with trap=1 -> mcause=0, mstatus=0x1800, mtvec=RESET_MTVEC.
